// File: rtl/div_sched.sv
// div_sched: round-robin scheduler sharing one multi-cycle divider between two requesters
module div_sched #(
  parameter int DATA_WIDTH = 64,
  parameter int DIV_LAT = 4
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  req0,
  input  logic [DATA_WIDTH-1:0] numer0,
  input  logic [DATA_WIDTH-1:0] denom0,
  output logic                  ack0,
  output logic                  done0,
  input  logic                  req1,
  input  logic [DATA_WIDTH-1:0] numer1,
  input  logic [DATA_WIDTH-1:0] denom1,
  output logic                  ack1,
  output logic                  done1,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remain,
  output logic                  div_err,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] div_numer,
  output logic [DATA_WIDTH-1:0] div_denom,
  input  logic [DATA_WIDTH-1:0] div_quotient,
  input  logic [DATA_WIDTH-1:0] div_remain
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state;
  logic [7:0] cnt;
  logic gid, last, grant;
  logic [DATA_WIDTH-1:0] sel_numer, sel_denom;
  // contention goes to whoever was not served last
  assign grant = req0 && req1 ? !last : req1;
  assign sel_numer = grant ? numer1 : numer0;
  assign sel_denom = grant ? denom1 : denom0;
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state <= IDLE;
      cnt <= '0;
      gid <= 1'b0;
      last <= 1'b1;
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      quotient <= '0;
      remain <= '0;
      div_err <= 1'b0;
      busy <= 1'b0;
      div_numer <= '0;
      div_denom <= '0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        IDLE:
          if (req0 || req1) begin
            gid <= grant;
            last <= grant;
            ack0 <= !grant;
            ack1 <= grant;
            busy <= 1'b1;
            // zero divisor never reaches the shared divider; answer locally
            if (sel_denom == '0) begin
              quotient <= '1;
              remain <= sel_numer;
              div_err <= 1'b1;
              done0 <= !grant;
              done1 <= grant;
              state <= DONE;
            end else begin
              div_numer <= sel_numer;
              div_denom <= sel_denom;
              cnt <= 8'(DIV_LAT - 1);
              state <= WAIT;
            end
          end
        WAIT:
          if (cnt != '0) cnt <= cnt - 8'd1;
          else begin
            quotient <= div_quotient;
            remain <= div_remain;
            div_err <= 1'b0;
            done0 <= !gid;
            done1 <= gid;
            state <= DONE;
          end
        default: begin
          busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_div_sched.sv
// tb_div_sched: two schedulers (settle latency 4 and 1) each driving a latency-modelled divider
module tb_div_sched;
  localparam int W = 64;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n[2];
  logic req0[2], req1[2], ack0[2], ack1[2], done0[2], done1[2], div_err[2], busy[2];
  logic [W-1:0] numer0[2], denom0[2], numer1[2], denom1[2];
  logic [W-1:0] quotient[2], remain[2], dn[2], dd[2], dq[2], dr[2];
  int checks = 0, errors = 0;
  int last[2];
  logic [W-1:0] exp_dn[2], exp_dd[2];

  for (genvar g = 0; g < 2; g++) begin : unit
    localparam int LAT = (g == 0) ? 4 : 1;
    logic [W-1:0] pn = '0, pd = '0, q, r;
    int scnt = 0;
    logic ok;
    div_sched #(.DATA_WIDTH(W), .DIV_LAT(LAT)) dut (
      .sys_clk(clk), .sys_rst_n(rst_n[g]),
      .req0(req0[g]), .numer0(numer0[g]), .denom0(denom0[g]), .ack0(ack0[g]), .done0(done0[g]),
      .req1(req1[g]), .numer1(numer1[g]), .denom1(denom1[g]), .ack1(ack1[g]), .done1(done1[g]),
      .quotient(quotient[g]), .remain(remain[g]), .div_err(div_err[g]), .busy(busy[g]),
      .div_numer(dn[g]), .div_denom(dd[g]), .div_quotient(dq[g]), .div_remain(dr[g]));
    // divider output is corrupted until operands have been stable for LAT cycles
    assign q = dd[g] == '0 ? '0 : dn[g] / dd[g];
    assign r = dd[g] == '0 ? '0 : dn[g] % dd[g];
    assign ok = LAT == 1 || (dn[g] === pn && dd[g] === pd && scnt >= LAT - 1);
    assign dq[g] = ok ? q : ~q;
    assign dr[g] = ok ? r : ~r ^ 64'h5;
    always @(posedge clk)
      if (dn[g] !== pn || dd[g] !== pd) begin
        pn <= dn[g];
        pd <= dd[g];
        scnt <= 1;
      end else if (scnt < 1000) scnt <= scnt + 1;
  end

  function automatic int lat(input int u);
    return u == 0 ? 4 : 1;
  endfunction

  function automatic logic [W-1:0] rnd_n();
    return {$urandom, $urandom} >> $urandom_range(0, 40);
  endfunction

  function automatic logic [W-1:0] rnd_d();
    case ($urandom_range(0, 3))
      0: return '0;
      1: return 64'($urandom_range(1, 20));
      default: return {$urandom, $urandom} >> $urandom_range(0, 60);
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic quiet(input int u);
    req0[u] = 1'b0;
    req1[u] = 1'b0;
  endtask

  task automatic op(input int u, input logic r0, input logic r1, input logic [W-1:0] n0,
                    input logic [W-1:0] d0, input logic [W-1:0] n1, input logic [W-1:0] d1);
    int g, kd;
    logic [W-1:0] n, d, eq, er;
    logic ee;
    logic [4:0] ex, ob;
    req0[u] = r0; req1[u] = r1;
    numer0[u] = n0; denom0[u] = d0; numer1[u] = n1; denom1[u] = d1;
    if (!r0 && !r1) begin
      tick;
      checks++;
      ob = {ack0[u], ack1[u], done0[u], done1[u], busy[u]};
      if (ob !== 5'b0) begin errors++; $display("FAIL u%0d no-request idle got=%b exp=00000", u, ob); end
      return;
    end
    g = (r0 && r1) ? 1 - last[u] : (r1 ? 1 : 0);
    last[u] = g;
    n = g == 1 ? n1 : n0;
    d = g == 1 ? d1 : d0;
    kd = d == '0 ? 1 : lat(u) + 1;
    if (d != '0) begin
      exp_dn[u] = n; exp_dd[u] = d;
      eq = n / d; er = n % d; ee = 1'b0;
    end else begin
      eq = '1; er = n; ee = 1'b1;
    end
    for (int k = 1; k <= kd; k++) begin
      tick;
      ex = {k == 1 && g == 0, k == 1 && g == 1, k == kd && g == 0, k == kd && g == 1, 1'b1};
      ob = {ack0[u], ack1[u], done0[u], done1[u], busy[u]};
      checks++;
      if (ob !== ex) begin errors++; $display("FAIL u%0d handshake k=%0d got=%b exp=%b", u, k, ob, ex); end
    end
    checks++;
    if ({quotient[u], remain[u], div_err[u]} !== {eq, er, ee}) begin
      errors++;
      $display("FAIL u%0d result got q=%h r=%h e=%b exp q=%h r=%h e=%b", u, quotient[u], remain[u], div_err[u], eq, er, ee);
    end
    checks++;
    if ({dn[u], dd[u]} !== {exp_dn[u], exp_dd[u]}) begin
      errors++;
      $display("FAIL u%0d operands got %h/%h exp %h/%h", u, dn[u], dd[u], exp_dn[u], exp_dd[u]);
    end
    tick;
    ob = {ack0[u], ack1[u], done0[u], done1[u], busy[u]};
    checks++;
    if (ob !== 5'b0) begin errors++; $display("FAIL u%0d return-to-idle got=%b exp=00000", u, ob); end
  endtask

  task automatic test_reset(input int u);
    logic [261:0] ob;
    quiet(u);
    rst_n[u] = 1'b0;
    tick;
    ob = {ack0[u], ack1[u], done0[u], done1[u], busy[u], div_err[u], quotient[u], remain[u], dn[u], dd[u]};
    checks++;
    if (ob !== '0) begin errors++; $display("FAIL u%0d reset outputs got=%h exp=0", u, ob); end
    rst_n[u] = 1'b1;
    last[u] = 1; exp_dn[u] = '0; exp_dd[u] = '0;
    tick;
  endtask

  task automatic test_single(input int u);
    op(u, 1'b1, 1'b0, 64'd1000, 64'd7, 64'd0, 64'd0);
    quiet(u);
  endtask

  task automatic test_contention(input int u);
    test_reset(u);
    op(u, 1'b1, 1'b1, 64'd1 << 40, 64'd3, 64'd100, 64'd10);
    op(u, 1'b0, 1'b1, 64'd0, 64'd0, 64'd100, 64'd10);
    quiet(u);
  endtask

  task automatic test_fairness(input int u);
    test_reset(u);
    for (int i = 0; i < 6; i++) op(u, 1'b1, 1'b1, rnd_n(), 64'd3 + 64'(i), rnd_n(), 64'd9 + 64'(i));
    quiet(u);
  endtask

  task automatic test_div_zero(input int u);
    op(u, 1'b1, 1'b0, 64'd77, 64'd5, 64'd0, 64'd0);
    op(u, 1'b0, 1'b1, 64'd0, 64'd0, 64'd55, 64'd0);
    quiet(u);
  endtask

  task automatic test_reset_mid(input int u);
    logic [261:0] ob;
    logic [2:0] hs;
    req0[u] = 1'b1; req1[u] = 1'b0; numer0[u] = 64'd999; denom0[u] = 64'd4;
    tick;
    checks++;
    if (ack0[u] !== 1'b1) begin errors++; $display("FAIL u%0d pre-reset ack0 got=%b exp=1", u, ack0[u]); end
    quiet(u);
    tick;
    rst_n[u] = 1'b0;
    #1;
    ob = {ack0[u], ack1[u], done0[u], done1[u], busy[u], div_err[u], quotient[u], remain[u], dn[u], dd[u]};
    checks++;
    if (ob !== '0) begin errors++; $display("FAIL u%0d async reset outputs got=%h exp=0", u, ob); end
    @(posedge clk);
    #1;
    rst_n[u] = 1'b1;
    last[u] = 1; exp_dn[u] = '0; exp_dd[u] = '0;
    repeat (lat(u) + 3) begin
      tick;
      hs = {done0[u], ack0[u], busy[u]};
      checks++;
      if (hs !== 3'b0) begin errors++; $display("FAIL u%0d post-reset activity got=%b exp=000", u, hs); end
    end
    op(u, 1'b1, 1'b0, 64'd1234, 64'd10, 64'd0, 64'd0);
    quiet(u);
  endtask

  task automatic test_boundary(input int u);
    op(u, 1'b1, 1'b0, '1, 64'd1, 64'd0, 64'd0);
    op(u, 1'b0, 1'b1, 64'd0, 64'd0, '1, '1);
    op(u, 1'b1, 1'b0, 64'd5, 64'd9, 64'd0, 64'd0);
    quiet(u);
  endtask

  task automatic test_random(input int u, input int n);
    int p;
    for (int i = 0; i < n; i++) begin
      p = int'($urandom_range(0, 3));
      op(u, p[0], p[1], rnd_n(), rnd_d(), rnd_n(), rnd_d());
    end
    quiet(u);
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      rst_n[u] = 1'b0;
      req0[u] = 1'b0; req1[u] = 1'b0;
      numer0[u] = '0; denom0[u] = '0; numer1[u] = '0; denom1[u] = '0;
      last[u] = 1; exp_dn[u] = '0; exp_dd[u] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      test_reset(u);
      test_single(u);
      test_contention(u);
      test_fairness(u);
      test_div_zero(u);
      test_reset_mid(u);
      test_boundary(u);
      test_random(u, 60);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/div_sched.md
Name: div_sched

Overview:
- Two-requester scheduler that shares one 64/64 unsigned divider between DDS frequency/phase computations (for example, the channel A and channel B tuning-word calculators).
- Arbitrates requests round-robin, drives registered operands to the shared divider, and waits a fixed settle latency.
- Captures quotient and remainder, then returns the result to the granted requester with a one-cycle done pulse.
- Divide-by-zero is trapped locally and never issued to the divider.

Parameters:
- DATA_WIDTH, 64, operand and result width.
- DIV_LAT, 4, cycles the divider outputs need to settle after operands change; legal range 1..255.

Ports:
- sys_clk  in  1  system clock, all logic on rising edge
- sys_rst_n  in  1  asynchronous active-low reset
- req0  in  1  requester 0 request (level)
- numer0  in  DATA_WIDTH  requester 0 dividend
- denom0  in  DATA_WIDTH  requester 0 divisor
- ack0  out  1  one-cycle pulse: request 0 accepted, operands sampled
- done0  out  1  one-cycle pulse: result valid for requester 0
- req1, numer1, denom1, ack1, done1: as above for requester 1
- quotient  out  DATA_WIDTH  result quotient, shared, valid with done0/done1
- remain  out  DATA_WIDTH  result remainder, shared
- div_err  out  1  divide-by-zero flag, valid with done0/done1
- busy  out  1  high whenever state is not IDLE
- div_numer  out  DATA_WIDTH  to shared divider numer
- div_denom  out  DATA_WIDTH  to shared divider denom
- div_quotient  in  DATA_WIDTH  from shared divider quotient
- div_remain  in  DATA_WIDTH  from shared divider remain

Behaviour:
- Reset (async, sys_rst_n=0):
  - State is IDLE.
  - All outputs are 0: ack, done, quotient, remain, div_err, busy, div_numer, div_denom.
  - Wait counter is 0.
  - last_grant is 1, so requester 0 wins the first contention.
- FSM states:
  - IDLE: sample req0/req1.
  - WAIT: count the divider settle time.
  - DONE: present the result.
- IDLE, arbitration:
  - Only one req high: that requester is granted.
  - Both high: the requester not equal to last_grant is granted.
  - None high: stay in IDLE.
- IDLE, on a grant (request cycle T):
  - Latch the granted numer/denom into div_numer/div_denom.
  - Record grant id and update last_grant.
  - Load counter with DIV_LAT-1.
- Normal request timing:
  - ack pulses for the granted requester in cycle T+1.
  - div_numer/div_denom are valid from T+1 and held stable until the next grant.
- WAIT:
  - Counter nonzero: decrement.
  - Counter zero: register div_quotient→quotient, div_remain→remain, div_err←0, then go to DONE.
  - WAIT occupies cycles T+1..T+DIV_LAT.
- DONE:
  - Occupies cycle T+DIV_LAT+1; the granted requester's done is high for exactly that cycle.
  - Next state is always IDLE (cycle T+DIV_LAT+2).
  - Throughput is one operation per DIV_LAT+2 cycles.
- Divide-by-zero (latched denom == 0):
  - In the IDLE grant cycle, go directly to DONE; do not update div_numer/div_denom.
  - Load quotient = all ones, remain = numer, div_err = 1.
  - ack and done both pulse in T+1; state returns to IDLE at T+2.
- Result hold: quotient/remain/div_err hold their values until the next capture.
- Requester rules:
  - Operands must be stable in the cycle req is high in IDLE; they are don't-care afterwards.
  - req is sampled only in IDLE. Requesters deassert req by their done cycle; req still high in IDLE counts as a new request.
  - A request arriving during WAIT/DONE is held by the requester and served at the next IDLE.
- Fairness: with both requesters continuously asserting, grants alternate 0,1,0,1.
- Reset mid-operation aborts the operation immediately; no ack/done is produced afterwards.

Test Plan:
1. Single op: DIV_LAT=4, req0 with numer0=1000, denom0=7 at cycle T -> ack0 at T+1; done0 at T+5 with quotient=142, remain=6, div_err=0; busy high T+1..T+5.
2. Contention after reset: req0 and req1 both high at the same IDLE cycle -> requester 0 is served first, then requester 1 at the next IDLE. Each done carries the correct result, e.g. 2^40/3 → 366503875925, rem 1, and 100/10 → 10, rem 0.
3. Fairness: req0 and req1 held high for 6 operations -> grant order 0,1,0,1,0,1, with no done pulses in the same cycle.
4. Divide-by-zero: numer1=55, denom1=0 -> ack1 and done1 at T+1, quotient=0xFFFF_FFFF_FFFF_FFFF, remain=55, div_err=1; div_numer/div_denom unchanged.
5. Async reset mid-WAIT: assert sys_rst_n=0 at T+2 for 1 cycle -> all outputs 0 immediately; no done0 pulse; next request proceeds normally.
6. Boundary values: numer=2^64-1, denom=1 -> quotient=2^64-1, remain=0. Also DIV_LAT=1 -> done at T+2.
